pong_game_engine: RTL

Parametrised two-player Pong game core. It owns the ball physics, paddle movement, scoring and the game-state machine. It advances one step per frame tick and drives registered object positions to the pixel renderer and scores to the seven-segment displays. Over the first generation it adds per-player scoring, a timed serve, speed-up on rallies, a win condition, and sign-based one-bounce-per-contact logic in place of bounce-enable latches.

---
 rtl/pong_game_engine.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_game_engine.sv
// rtl/pong_game_engine.sv - two-player Pong core: ball physics, paddles, scoring and game FSM
module pong_game_engine #(
  parameter int H_RES            = 640,
  parameter int V_RES            = 480,
  parameter int BALL_SIZE        = 25,
  parameter int PADDLE_W         = 10,
  parameter int PADDLE_H         = 150,
  parameter int PADDLE_L_X       = 40,
  parameter int PADDLE_R_X       = 600,
  parameter int PADDLE_SPEED     = 6,
  parameter int BALL_SPEED       = 4,
  parameter int MAX_SPEED        = 10,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int WIN_SCORE        = 9,
  parameter int SERVE_DELAY      = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       up_l,
  input  logic       dn_l,
  input  logic       up_r,
  input  logic       dn_r,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_l_y,
  output logic [9:0] paddle_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic       hit_pulse,
  output logic       point_pulse
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [9:0]  CX         = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  CY         = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  PC         = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [9:0]  BALL_X_MAX = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0]  BALL_Y_MAX = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0]  L_FACE     = 10'(PADDLE_L_X + PADDLE_W);
  localparam logic [9:0]  R_PARK     = 10'(PADDLE_R_X - BALL_SIZE);
  localparam logic signed [11:0] S_BSZ   = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_PH    = 12'(PADDLE_H);
  localparam logic signed [11:0] S_LFACE = 12'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [11:0] S_RX    = 12'(PADDLE_R_X);
  localparam logic signed [11:0] S_XMAX  = 12'(H_RES - BALL_SIZE);
  localparam logic signed [11:0] S_YMAX  = 12'(V_RES - BALL_SIZE);
  localparam logic signed [11:0] S_PMAX  = 12'(V_RES - PADDLE_H);
  localparam logic signed [11:0] S_PSPD  = 12'(PADDLE_SPEED);
  localparam logic [4:0]  SPD_INIT   = 5'(BALL_SPEED);
  localparam logic [4:0]  SPD_MAX    = 5'(MAX_SPEED);
  localparam logic [7:0]  HITS_MAX   = 8'(HITS_PER_SPEEDUP);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_CNT  = 16'(SERVE_DELAY);

  state_t      state_q, state_d;
  logic [9:0]  bx_q, bx_d, by_q, by_d, pl_q, pl_d, pr_q, pr_d;
  logic [3:0]  sl_q, sl_d, sr_q, sr_d;
  logic [1:0]  win_q, win_d;
  logic [4:0]  spd_q, spd_d;
  logic [7:0]  hits_q, hits_d;
  logic [15:0] cnt_q, cnt_d;
  logic        vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d, serve_r_q, serve_r_d;
  logic        hit_q, hit_d, pt_q, pt_d;

  logic signed [11:0] spd_s, vx_s, vy_s, bx_s, nx, ny, pl_s, pr_s;
  logic               hit_l, hit_r;

  // Both velocity components always have magnitude spd_q; only their signs are stored.
  assign spd_s = $signed({7'd0, spd_q});
  assign vx_s  = vx_neg_q ? -spd_s : spd_s;
  assign vy_s  = vy_neg_q ? -spd_s : spd_s;
  assign bx_s  = $signed({2'b00, bx_q});
  assign nx    = bx_s + vx_s;
  assign ny    = $signed({2'b00, by_q}) + vy_s;
  assign pl_s  = $signed({2'b00, pl_q});
  assign pr_s  = $signed({2'b00, pr_q});

  assign hit_l = vx_neg_q && (bx_s >= S_LFACE) && (nx <= S_LFACE) &&
                 (ny + S_BSZ > pl_s) && (ny < pl_s + S_PH);
  assign hit_r = !vx_neg_q && (bx_s + S_BSZ <= S_RX) && (nx + S_BSZ >= S_RX) &&
                 (ny + S_BSZ > pr_s) && (ny < pr_s + S_PH);

  function automatic logic [9:0] move_paddle(input logic [9:0] y, input logic up,
                                             input logic dn);
    logic signed [11:0] t;
    t = $signed({2'b00, y});
    if (up && !dn) t = t - S_PSPD;
    else if (dn && !up) t = t + S_PSPD;
    if (t < 12'sd0) t = 12'sd0;
    else if (t > S_PMAX) t = S_PMAX;
    return t[9:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    by_d      = by_q;
    pl_d      = pl_q;
    pr_d      = pr_q;
    sl_d      = sl_q;
    sr_d      = sr_q;
    win_d     = win_q;
    spd_d     = spd_q;
    hits_d    = hits_q;
    cnt_d     = cnt_q;
    vx_neg_d  = vx_neg_q;
    vy_neg_d  = vy_neg_q;
    serve_r_d = serve_r_q;
    hit_d     = 1'b0;
    pt_d      = 1'b0;
    if (tick) begin
      if (state_q == S_SERVE || state_q == S_PLAY) begin
        pl_d = move_paddle(pl_q, up_l, dn_l);
        pr_d = move_paddle(pr_q, up_r, dn_r);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SERVE;
            cnt_d   = SERVE_CNT;
          end
        end
        S_SERVE: begin
          if (cnt_q <= 16'd1) begin
            state_d  = S_PLAY;
            cnt_d    = 16'd0;
            vx_neg_d = !serve_r_q;
            bx_d     = serve_r_q ? CX + {5'd0, spd_q} : CX - {5'd0, spd_q};
            by_d     = vy_neg_q ? CY - {5'd0, spd_q} : CY + {5'd0, spd_q};
          end else begin
            cnt_d = cnt_q - 16'd1;
            bx_d  = CX;
            by_d  = CY;
          end
        end
        S_PLAY: begin
          if (ny <= 12'sd0) begin
            by_d     = 10'd0;
            vy_neg_d = 1'b0;
          end else if (ny >= S_YMAX) begin
            by_d     = BALL_Y_MAX;
            vy_neg_d = 1'b1;
          end else begin
            by_d = ny[9:0];
          end
          if (hit_l || hit_r) begin
            hit_d    = 1'b1;
            vx_neg_d = hit_r;
            bx_d     = hit_l ? L_FACE : R_PARK;
            if (hits_q + 8'd1 == HITS_MAX) begin
              hits_d = 8'd0;
              if (spd_q < SPD_MAX) spd_d = spd_q + 5'd1;
            end else begin
              hits_d = hits_q + 8'd1;
            end
          end else if (nx <= 12'sd0 || nx >= S_XMAX) begin
            // Ball left the field: the next serve heads toward whoever let it through.
            pt_d      = 1'b1;
            serve_r_d = (nx > 12'sd0);
            vy_neg_d  = !vy_neg_d;
            spd_d     = SPD_INIT;
            hits_d    = 8'd0;
            cnt_d     = SERVE_CNT;
            if (nx > 12'sd0) begin
              bx_d = BALL_X_MAX;
              sl_d = sl_q + 4'd1;
            end else begin
              bx_d = 10'd0;
              sr_d = sr_q + 4'd1;
            end
            if (sl_d == WIN) begin
              state_d = S_OVER;
              win_d   = 2'd1;
            end else if (sr_d == WIN) begin
              state_d = S_OVER;
              win_d   = 2'd2;
            end else begin
              state_d = S_SERVE;
            end
          end else begin
            bx_d = nx[9:0];
          end
        end
        S_OVER: begin
          if (start) begin
            sl_d    = 4'd0;
            sr_d    = 4'd0;
            win_d   = 2'd0;
            spd_d   = SPD_INIT;
            hits_d  = 8'd0;
            state_d = S_SERVE;
            cnt_d   = SERVE_CNT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bx_q      <= CX;
      by_q      <= CY;
      pl_q      <= PC;
      pr_q      <= PC;
      sl_q      <= 4'd0;
      sr_q      <= 4'd0;
      win_q     <= 2'd0;
      spd_q     <= SPD_INIT;
      hits_q    <= 8'd0;
      cnt_q     <= 16'd0;
      vx_neg_q  <= 1'b0;
      vy_neg_q  <= 1'b0;
      serve_r_q <= 1'b1;
      hit_q     <= 1'b0;
      pt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      pl_q      <= pl_d;
      pr_q      <= pr_d;
      sl_q      <= sl_d;
      sr_q      <= sr_d;
      win_q     <= win_d;
      spd_q     <= spd_d;
      hits_q    <= hits_d;
      cnt_q     <= cnt_d;
      vx_neg_q  <= vx_neg_d;
      vy_neg_q  <= vy_neg_d;
      serve_r_q <= serve_r_d;
      hit_q     <= hit_d;
      pt_q      <= pt_d;
    end
  end

  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign paddle_l_y  = pl_q;
  assign paddle_r_y  = pr_q;
  assign score_l     = sl_q;
  assign score_r     = sr_q;
  assign state       = state_q;
  assign winner      = win_q;
  assign hit_pulse   = hit_q;
  assign point_pulse = pt_q;

endmodule
